// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - debounced button presses merged onto one round-robin valid/ready event stream
module btn_event_arbiter #(
    parameter int N_BTN       = 4,
    parameter int TICK_DIV    = 100_000,
    parameter int LOCK_MS     = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_lost,
    output logic [N_BTN-1:0]         busy
);
    localparam int IW = $clog2(N_BTN);
    localparam int CW = $clog2(LOCK_MS + 1);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LOCK_INIT = CW'(LOCK_MS);
    localparam logic [PW-1:0] DIV_LAST  = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, P_LOCK, HELD, R_LOCK} state_t;

    logic [N_BTN-1:0] sync_q [SYNC_STAGES];
    logic [N_BTN-1:0] btn_s;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    state_t           state_q [N_BTN];
    state_t           state_d [N_BTN];
    logic [CW-1:0]    cnt_q   [N_BTN];
    logic [CW-1:0]    cnt_d   [N_BTN];
    logic [N_BTN-1:0] set, grant, pending_q, pending_d;
    logic             valid_q, valid_d, lost_q, lost_d, load, found;
    logic [IW-1:0]    id_q, id_d, rr_q, rr_d, winner, idx;

    assign btn_s     = sync_q[SYNC_STAGES-1];
    assign tick      = (presc_q == DIV_LAST);
    assign presc_d   = tick ? '0 : presc_q + PW'(1);
    assign evt_valid = valid_q;
    assign evt_id    = id_q;
    assign evt_lost  = lost_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            presc_q <= '0;
        end else begin
            sync_q[0] <= btn;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            presc_q <= presc_d;
        end
    end

    // Lock windows ignore btn_s so bounce cannot create extra presses
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            set[i]     = 1'b0;
            busy[i]    = (state_q[i] != IDLE);
            case (state_q[i])
                IDLE: if (btn_s[i]) begin
                    state_d[i] = P_LOCK;
                    cnt_d[i]   = LOCK_INIT;
                    set[i]     = 1'b1;
                end
                P_LOCK: if (tick) begin
                    if (cnt_q[i] == CW'(1)) begin
                        if (btn_s[i]) begin
                            state_d[i] = HELD;
                        end else begin
                            state_d[i] = R_LOCK;
                            cnt_d[i]   = LOCK_INIT;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                    end
                end
                HELD: if (!btn_s[i]) begin
                    state_d[i] = R_LOCK;
                    cnt_d[i]   = LOCK_INIT;
                end
                R_LOCK: if (tick) begin
                    if (cnt_q[i] == CW'(1)) state_d[i] = IDLE;
                    else                    cnt_d[i]   = cnt_q[i] - CW'(1);
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        load   = !valid_q || evt_ready;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        grant  = '0;
        for (int k = 0; k < N_BTN; k++) begin
            idx = IW'((int'(rr_q) + k) % N_BTN);
            if (!found && pending_q[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        if (load && found) grant[winner] = 1'b1;
        // A fresh press in the grant cycle re-arms pending instead of being lost
        pending_d = set | (pending_q & ~grant);
        lost_d    = |(set & pending_q & ~grant);
        valid_d   = load ? found : valid_q;
        id_d      = (load && found) ? winner : id_q;
        rr_d      = rr_q;
        if (load && found) rr_d = (winner == IW'(N_BTN - 1)) ? '0 : winner + IW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            pending_q <= '0;
            valid_q   <= 1'b0;
            lost_q    <= 1'b0;
            id_q      <= '0;
            rr_q      <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pending_q <= pending_d;
            valid_q   <= valid_d;
            lost_q    <= lost_d;
            id_q      <= id_d;
            rr_q      <= rr_d;
        end
    end
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb/tb_btn_event_arbiter.sv - directed bench for btn_event_arbiter with short ticks and locks
module tb_btn_event_arbiter;
    logic       clk, rst_n, evt_valid, evt_ready, evt_lost;
    logic [3:0] btn, busy;
    logic [1:0] evt_id;
    int errors = 0, checks = 0;
    int ev_cnt = 0, lost_cnt = 0, base, lbase;
    int ev_ids[$];

    btn_event_arbiter #(.N_BTN(4), .TICK_DIV(10), .LOCK_MS(3), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_id(evt_id), .evt_lost(evt_lost), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            if (evt_valid && evt_ready) begin
                ev_cnt++;
                ev_ids.push_back(int'(evt_id));
            end
            if (evt_lost) lost_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        clk = 0; rst_n = 1; btn = '0; evt_ready = 1;

        // reset asserted between edges
        #13 rst_n = 0;
        #1;
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_lost", 32'(evt_lost), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_id", 32'(evt_id), 0);
        cyc(5);
        chk("rst_hold_valid", 32'(evt_valid), 0);
        chk("rst_hold_busy", 32'(busy), 0);
        rst_n = 1;
        cyc(2);

        // simultaneous presses, round-robin order
        base = ev_cnt;
        btn = 4'b1001;
        cyc(3);
        chk("pair1_early", 32'(evt_valid), 0);
        cyc(1);
        chk("pair1_v0", 32'(evt_valid), 1);
        chk("pair1_id0", 32'(evt_id), 0);
        cyc(1);
        chk("pair1_v1", 32'(evt_valid), 1);
        chk("pair1_id1", 32'(evt_id), 3);
        cyc(1);
        chk("pair1_idle", 32'(evt_valid), 0);
        cyc(40); btn = '0; cyc(40);
        btn = 4'b1010;
        cyc(4);
        chk("pair2_id0", 32'(evt_id), 1);
        cyc(1);
        chk("pair2_v1", 32'(evt_valid), 1);
        chk("pair2_id1", 32'(evt_id), 3);
        cyc(40); btn = '0; cyc(40);
        chk("pair_count", 32'(ev_cnt - base), 4);
        chk("pair_order", 32'(ev_ids[base+2]), 1);

        // bouncing press then long hold
        base = ev_cnt;
        for (int c = 0; c < 15; c++) begin
            btn[2] = (c % 2 == 0);
            @(negedge clk);
            if (c == 2) chk("bounce_early", 32'(evt_valid), 0);
            if (c == 3) begin
                chk("bounce_valid", 32'(evt_valid), 1);
                chk("bounce_id", 32'(evt_id), 2);
                chk("bounce_busy", 32'(busy[2]), 1);
            end
        end
        cyc(100);
        chk("held_busy", 32'(busy[2]), 1);
        btn[2] = 0;
        cyc(5);
        chk("rlock_busy", 32'(busy[2]), 1);
        cyc(40);
        chk("idle_busy", 32'(busy[2]), 0);
        chk("bounce_count", 32'(ev_cnt - base), 1);

        // backpressure: pending then lost
        evt_ready = 0;
        base = ev_cnt; lbase = lost_cnt;
        for (int p = 0; p < 3; p++) begin
            btn[1] = 1; cyc(40); btn[1] = 0; cyc(40);
            chk($sformatf("bp_valid%0d", p), 32'(evt_valid), 1);
            chk($sformatf("bp_id%0d", p), 32'(evt_id), 1);
        end
        chk("bp_lost", 32'(lost_cnt - lbase), 1);
        chk("bp_none", 32'(ev_cnt - base), 0);
        evt_ready = 1;
        cyc(5);
        chk("bp_drain", 32'(ev_cnt - base), 2);
        chk("bp_empty", 32'(evt_valid), 0);

        // held press, bouncing release
        base = ev_cnt;
        btn[3] = 1; cyc(50);
        for (int c = 0; c < 8; c++) begin
            btn[3] = (c % 2 == 1);
            @(negedge clk);
        end
        btn[3] = 0;
        cyc(5);
        chk("rel_busy", 32'(busy[3]), 1);
        cyc(40);
        chk("rel_idle", 32'(busy[3]), 0);
        chk("rel_count", 32'(ev_cnt - base), 1);

        // reset during lock with a waiting event
        evt_ready = 0; lbase = lost_cnt;
        btn[0] = 1;
        cyc(4);
        chk("r6_valid", 32'(evt_valid), 1);
        chk("r6_id", 32'(evt_id), 0);
        cyc(5);
        chk("r6_busy", 32'(busy[0]), 1);
        #2 rst_n = 0;
        #1;
        chk("r6_rst_valid", 32'(evt_valid), 0);
        chk("r6_rst_busy", 32'(busy), 0);
        btn = '0;
        cyc(3);
        rst_n = 1; evt_ready = 1;
        cyc(5);
        chk("r6_gone", 32'(evt_valid), 0);
        base = ev_cnt;
        btn[0] = 1;
        cyc(3);
        chk("r6_early", 32'(evt_valid), 0);
        cyc(1);
        chk("r6_new_valid", 32'(evt_valid), 1);
        chk("r6_new_id", 32'(evt_id), 0);
        cyc(40); btn = '0; cyc(40);
        chk("r6_count", 32'(ev_cnt - base), 1);
        chk("r6_nolost", 32'(lost_cnt - lbase), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
